dfd_univ_reg: RTL



---
 rtl/dfd_pkg.sv | 16 +
 rtl/dfd_bit.sv | 29 ++
 rtl/dfd_univ_reg.sv | 91 +++++++++
 3 files changed

// File: rtl/dfd_pkg.sv
// Shared definitions for the universal register: mode encoding.
// All eight 3-bit codes are defined.
package dfd_pkg;

    localparam int MODE_W = 3;

    localparam logic [MODE_W-1:0] MODE_HOLD = 3'd0;
    localparam logic [MODE_W-1:0] MODE_LOAD = 3'd1;
    localparam logic [MODE_W-1:0] MODE_SHL  = 3'd2;
    localparam logic [MODE_W-1:0] MODE_SHR  = 3'd3;
    localparam logic [MODE_W-1:0] MODE_ROL  = 3'd4;
    localparam logic [MODE_W-1:0] MODE_ROR  = 3'd5;
    localparam logic [MODE_W-1:0] MODE_CLR  = 3'd6;
    localparam logic [MODE_W-1:0] MODE_INV  = 3'd7;

endpackage

// File: rtl/dfd_bit.sv
// One storage bit with a true flop and a separate complement flop,
// both loaded from the same D so qbar_o is always ~q_o, even in reset.
module dfd_bit #(
    parameter logic RESET_BIT = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o,
    output logic qbar_o
);

    logic q_q;
    logic qbar_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q    <= RESET_BIT;
            qbar_q <= ~RESET_BIT;
        end else begin
            q_q    <= d_i;
            qbar_q <= ~d_i;
        end
    end

    assign q_o    = q_q;
    assign qbar_o = qbar_q;

endmodule

// File: rtl/dfd_univ_reg.sv
// WIDTH-bit universal register: load, shift, rotate, clear and invert per
// cycle, with complementary outputs and registered change/zero flags.
module dfd_univ_reg
    import dfd_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [MODE_W-1:0] mode,
    input  logic [WIDTH-1:0]  d,
    input  logic              sin_l,
    input  logic              sin_r,
    output logic [WIDTH-1:0]  Q,
    output logic [WIDTH-1:0]  Qbar,
    output logic              sout_l,
    output logic              sout_r,
    output logic              chg,
    output logic              zero
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] qbar_q;
    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] shl_v;
    logic [WIDTH-1:0] shr_v;
    logic [WIDTH-1:0] rol_v;
    logic [WIDTH-1:0] ror_v;
    logic             chg_q;
    logic             zero_q;

    // Shift/rotate candidates are built by overwriting the vacated bit, which
    // keeps WIDTH == 1 legal: shifts take the serial input, rotates hold.
    always_comb begin
        shl_v           = q_q << 1;
        shl_v[0]        = sin_r;
        shr_v           = q_q >> 1;
        shr_v[WIDTH-1]  = sin_l;
        rol_v           = q_q << 1;
        rol_v[0]        = q_q[WIDTH-1];
        ror_v           = q_q >> 1;
        ror_v[WIDTH-1]  = q_q[0];

        q_d = q_q;
        if (en) begin
            case (mode)
                MODE_HOLD: q_d = q_q;
                MODE_LOAD: q_d = d;
                MODE_SHL:  q_d = shl_v;
                MODE_SHR:  q_d = shr_v;
                MODE_ROL:  q_d = rol_v;
                MODE_ROR:  q_d = ror_v;
                MODE_CLR:  q_d = RESET_VAL;
                MODE_INV:  q_d = ~q_q;
                default:   q_d = q_q;
            endcase
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        dfd_bit #(
            .RESET_BIT (RESET_VAL[i])
        ) u_bit (
            .clk    (clk),
            .rst_n  (rst_n),
            .d_i    (q_d[i]),
            .q_o    (q_q[i]),
            .qbar_o (qbar_q[i])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chg_q  <= 1'b0;
            zero_q <= (RESET_VAL == '0);
        end else begin
            chg_q  <= (q_d != q_q);
            zero_q <= (q_d == '0);
        end
    end

    assign Q      = q_q;
    assign Qbar   = qbar_q;
    assign sout_l = q_q[WIDTH-1];
    assign sout_r = q_q[0];
    assign chg    = chg_q;
    assign zero   = zero_q;

endmodule
